mul_share_ctrl: RTL
===================

Name: mul_share_ctrl

Overview:
- Sequencing and arbitration controller for the shared 32x32 Wallace multiplier datapath (partial-product generator plus reduction tree).
- Accepts operand pairs from two requesters and grants them round-robin.
- Drives the multiplier operand bus, waits the fixed datapath latency, then captures the 64-bit product.
- Returns the product on one response channel tagged with the requester id.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- LAT, 2, cycles from mul_a/mul_b stable to mul_p valid. Must be >= 1; the cycle count is checked at elaboration.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  requester 0 multiplicand
- req0_b  in  WIDTH  requester 0 multiplier
- req1_valid  in  1  requester 1 has an operand pair
- req1_ready  out  1  requester 1 accepted this cycle
- req1_a  in  WIDTH  requester 1 multiplicand
- req1_b  in  WIDTH  requester 1 multiplier
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer takes the product
- rsp_id  out  1  requester the product belongs to
- rsp_p  out  2*WIDTH  unsigned product
- mul_a  out  WIDTH  operand A to the multiplier datapath
- mul_b  out  WIDTH  operand B to the multiplier datapath
- mul_p  in  2*WIDTH  product from the multiplier datapath
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset values (rst_n low at a clk edge): state=IDLE, last_grant=1 (so requester 0 wins the first tie), mul_a=0, mul_b=0, rsp_p=0, rsp_id=0, rsp_valid=0, busy=0, cnt=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, ready generation:
  - reqN_ready is combinational and asserted only in IDLE, and only for the granted requester.
  - Grant rule: if only one valid, grant it; if both valid, grant !last_grant.
  - Both readys are never high together.
  - Ready never depends on the requester's own valid being removed.
- IDLE, handshake (valid&&ready at an edge):
  - Register a/b into mul_a/mul_b and the id into rsp_id.
  - Set last_grant=id, cnt=LAT-1, go to BUSY.
- BUSY:
  - mul_a/mul_b are held constant.
  - If cnt==0, capture mul_p into rsp_p and go to DONE; otherwise decrement cnt.
  - With LAT=1, BUSY lasts exactly one cycle.
- Latency: accept at edge k; rsp_valid rises after edge k+LAT; rsp_p is valid the same cycle.
- DONE:
  - rsp_valid=1; rsp_p, rsp_id, mul_a and mul_b all held.
  - On rsp_valid&&rsp_ready go to IDLE.
  - rsp_valid is held indefinitely under back-pressure; no new request is accepted while in DONE.
- Throughput: the next accept is at the earliest one cycle after the response handshake, so one product per LAT+2 cycles minimum.
- Requesters hold a/b stable while valid is high. The controller samples them only at the handshake edge.
- Arithmetic: unsigned; rsp_p is a straight copy of mul_p with no truncation or sign handling.
- Reset mid-operation (BUSY or DONE):
  - Abort and return to IDLE with the reset values above.
  - The in-flight product is dropped; no response is issued for it.
- A request valid that drops without a handshake is ignored; no state change.

Decomposition:
- Package mul_share_pkg:
  - state enum {IDLE, BUSY, DONE};
  - default WIDTH/LAT constants;
  - requester id type (1 bit).
- One sub-module: rr_arb2, a combinational 2-way round-robin grant taking last_grant and the two valids, returning the grant vector. The FSM, counter and datapath registers stay in mul_share_ctrl.
- The multiplier itself is external and connected at the next level up.

Test Plan:
- Single request, LAT=2, req0 a=5 b=7; bench multiplier returns a*b after 2 cycles -> rsp_valid rises 2 cycles after accept with rsp_p=35, rsp_id=0; busy high from accept until the response handshake.
- Both valid in the same cycle out of reset (req0 a=3 b=4, req1 a=6 b=9) -> req0 served first (12, id 0), then req1 (54, id 1); readys never both high.
- Fairness: both requesters hold valid for 4 transactions -> ids alternate 0,1,0,1.
- Back-pressure: rsp_ready low for 5 cycles in DONE -> rsp_valid, rsp_p and mul_a/mul_b stable; req0/req1 ready stay low; completes when rsp_ready rises.
- Boundary operands a=b=0xFFFFFFFF -> rsp_p=0xFFFFFFFE00000001; a=0 b=0xDEADBEEF -> rsp_p=0.
- rst_n low for 1 cycle during BUSY -> next cycle state IDLE, rsp_valid=0, mul_a=mul_b=0, no response for the aborted op; next tie grants requester 0.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the multiplier-sharing controller slice.
// State encoding, requester id type and default datapath geometry.
package mul_share_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LAT   = 2;

    typedef logic id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Request/response/datapath bundle of the multiplier-sharing controller.
// master = requesters, consumer and multiplier side; slave = the controller.
interface mul_share_ctrl_if
    import mul_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               rsp_valid;
    logic               rsp_ready;
    id_t                rsp_id;
    logic [2*WIDTH-1:0] rsp_p;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_p;
    logic               busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready, mul_p,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p,
        input  mul_a, mul_b, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready, mul_p,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p,
        output mul_a, mul_b, busy
    );

endinterface

// File: rtl/mul_share_ctrl_rr_arb2.sv
// Two-way round-robin grant; purely combinational, zero latency.
// A lone valid always wins; on a tie the requester not granted last time wins.
module rr_arb2
    import mul_share_pkg::*;
(
    input  id_t        last_grant_i,
    input  logic [1:0] vld_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (vld_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Arbitrates two requesters onto one external multiplier; product returns LAT cycles after accept.
// Response is held in DONE under back-pressure and no new request is accepted until it drains.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT
)(
    input  logic             clk,
    input  logic             rst_n,
    mul_share_ctrl_if.slave  bus
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    generate
        if (LAT < 1) begin : g_lat_chk
            $error("mul_share_ctrl: LAT must be at least 1");
        end
    endgenerate

    logic [1:0]         state_q, state_d;
    id_t                last_grant_q, last_grant_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] rsp_p_q, rsp_p_d;
    id_t                rsp_id_q, rsp_id_d;
    logic [1:0]         gnt;

    rr_arb2 u_arb (
        .last_grant_i (last_grant_q),
        .vld_i        ({bus.req1_valid, bus.req0_valid}),
        .gnt_o        (gnt)
    );

    // Grant only reaches the requesters while idle, so a held valid never
    // sees ready during BUSY/DONE.
    assign bus.req0_ready = (state_q == ST_IDLE) && gnt[0];
    assign bus.req1_ready = (state_q == ST_IDLE) && gnt[1];
    assign bus.rsp_valid  = (state_q == ST_DONE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rsp_p      = rsp_p_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_p_d      = rsp_p_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    mul_a_d      = gnt[1] ? bus.req1_a : bus.req0_a;
                    mul_b_d      = gnt[1] ? bus.req1_b : bus.req0_b;
                    rsp_id_d     = gnt[1];
                    last_grant_d = gnt[1];
                    cnt_d        = CW'(LAT - 1);
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    rsp_p_d = bus.mul_p;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_p_q      <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_p_q      <= rsp_p_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

endmodule
